// File: rtl/ml_sync_core.sv
// ml_sync_core: CP-based maximum-likelihood timing estimator.
// Computes sliding-window correlation (gamma) and energy (phi) against the N-lag copy,
// forms lambda = |gamma|approx - rho*phi, and reports the per-symbol argmax together
// with the complex gamma at the peak. Four valid-tagged stages; in_valid gaps freeze
// all sliding state so results match a gap-free stream.
module ml_sync_core #(
    parameter int unsigned N        = 256,
    parameter int unsigned L        = 16,
    parameter int unsigned W_IN     = 8,
    parameter int unsigned RHO_W    = 8,
    parameter int unsigned RHO_FRAC = 7,
    localparam int unsigned NW      = $clog2(N),
    localparam int unsigned GW      = 2 * W_IN + 1 + $clog2(L)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic signed [W_IN-1:0] rx_re_in,
    input  logic signed [W_IN-1:0] rx_img_in,
    input  logic [RHO_W-1:0]       rho,
    output logic [NW-1:0]          theta,
    output logic signed [GW-1:0]   gamma_re,
    output logic signed [GW-1:0]   gamma_im,
    output logic signed [GW+1:0]   lambda_max,
    output logic                   out_valid
);

    localparam int unsigned PW  = 2 * W_IN + 1;     // product / energy width
    localparam int unsigned EXT = GW - PW;          // growth of the L-term sums
    localparam int unsigned LW  = GW + 2;           // lambda width
    localparam int unsigned MW  = GW + 1;           // magnitude approximation width
    localparam int unsigned PRW = GW + RHO_W;       // rho * phi full product width
    localparam int unsigned SW  = $clog2(N + L);
    localparam logic [SW-1:0] SLag  = SW'(N);
    localparam logic [SW-1:0] SFull = SW'(N + L - 1);
    localparam logic [NW-1:0] CLast = NW'(N - 1);

    // Acceptance: clear cycles discard the incoming sample.
    logic acc;
    assign acc = in_valid && !clear;

    // ---------------- Delay line and counters ----------------
    logic [2*W_IN-1:0] dline_q [N];
    logic [NW-1:0]     wp_q;
    logic [SW-1:0]     s_q;     // accepted samples so far, saturates at N+L-1
    logic [NW-1:0]     c_q;     // candidate index of the next accepted sample

    // Circular N-deep sample store; old value is read combinationally before the write.
    always_ff @(posedge clk) begin
        if (rst && acc) begin
            dline_q[wp_q] <= {rx_re_in, rx_img_in};
        end
    end

    // ---------------- Stage 1: product and energy ----------------
    logic signed [W_IN-1:0]   ar, ai, dr, di;
    logic signed [2*W_IN-1:0] p_ac, p_bd, p_bc, p_ad, sq_a, sq_b, sq_c, sq_d;
    logic signed [PW-1:0]     p_re_d, p_im_d;
    logic [PW-1:0]            e_d;

    // p = r_s * conj(r_{s-N}); e = |r_s|^2 + |r_{s-N}|^2.
    always_comb begin
        ar     = rx_re_in;
        ai     = rx_img_in;
        dr     = dline_q[wp_q][2*W_IN-1:W_IN];
        di     = dline_q[wp_q][W_IN-1:0];
        p_ac   = (2*W_IN)'(ar) * (2*W_IN)'(dr);
        p_bd   = (2*W_IN)'(ai) * (2*W_IN)'(di);
        p_bc   = (2*W_IN)'(ai) * (2*W_IN)'(dr);
        p_ad   = (2*W_IN)'(ar) * (2*W_IN)'(di);
        sq_a   = (2*W_IN)'(ar) * (2*W_IN)'(ar);
        sq_b   = (2*W_IN)'(ai) * (2*W_IN)'(ai);
        sq_c   = (2*W_IN)'(dr) * (2*W_IN)'(dr);
        sq_d   = (2*W_IN)'(di) * (2*W_IN)'(di);
        p_re_d = {p_ac[2*W_IN-1], p_ac} + {p_bd[2*W_IN-1], p_bd};
        p_im_d = {p_bc[2*W_IN-1], p_bc} - {p_ad[2*W_IN-1], p_ad};
        e_d    = {1'b0, sq_a} + {1'b0, sq_b} + {1'b0, sq_c} + {1'b0, sq_d};
    end

    logic signed [PW-1:0] p1_re_q, p1_im_q;
    logic [PW-1:0]        e1_q;
    logic                 v1_q, cand1_q;
    logic [NW-1:0]        c1_q;

    // Counters advance on acceptance; stage-1 registers advance every cycle.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wp_q    <= '0;
            s_q     <= '0;
            c_q     <= '0;
            p1_re_q <= '0;
            p1_im_q <= '0;
            e1_q    <= '0;
            v1_q    <= 1'b0;
            cand1_q <= 1'b0;
            c1_q    <= '0;
        end else begin
            if (acc) begin
                wp_q <= wp_q + NW'(1);
                if (s_q != SFull) begin
                    s_q <= s_q + SW'(1);
                end else begin
                    c_q <= c_q + NW'(1);
                end
            end
            p1_re_q <= p_re_d;
            p1_im_q <= p_im_d;
            e1_q    <= e_d;
            v1_q    <= acc && (s_q >= SLag);
            cand1_q <= acc && (s_q == SFull);
            c1_q    <= c_q;
        end
    end

    // ---------------- Stage 2: sliding window sums ----------------
    logic signed [PW-1:0] fifo_re_q [L];
    logic signed [PW-1:0] fifo_im_q [L];
    logic [PW-1:0]        fifo_e_q  [L];
    logic signed [GW-1:0] gsum_re_q, gsum_im_q;
    logic [GW-1:0]        esum_q;
    logic                 v2_q;
    logic [NW-1:0]        c2_q;

    // Add the newest term, drop the one from L valid products ago.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < L; i++) begin
                fifo_re_q[i] <= '0;
                fifo_im_q[i] <= '0;
                fifo_e_q[i]  <= '0;
            end
            gsum_re_q <= '0;
            gsum_im_q <= '0;
            esum_q    <= '0;
            v2_q      <= 1'b0;
            c2_q      <= '0;
        end else begin
            if (v1_q) begin
                gsum_re_q <= gsum_re_q + {{EXT{p1_re_q[PW-1]}}, p1_re_q}
                             - {{EXT{fifo_re_q[L-1][PW-1]}}, fifo_re_q[L-1]};
                gsum_im_q <= gsum_im_q + {{EXT{p1_im_q[PW-1]}}, p1_im_q}
                             - {{EXT{fifo_im_q[L-1][PW-1]}}, fifo_im_q[L-1]};
                esum_q    <= esum_q + {{EXT{1'b0}}, e1_q} - {{EXT{1'b0}}, fifo_e_q[L-1]};
                fifo_re_q[0] <= p1_re_q;
                fifo_im_q[0] <= p1_im_q;
                fifo_e_q[0]  <= e1_q;
                for (int i = 1; i < L; i++) begin
                    fifo_re_q[i] <= fifo_re_q[i-1];
                    fifo_im_q[i] <= fifo_im_q[i-1];
                    fifo_e_q[i]  <= fifo_e_q[i-1];
                end
            end
            v2_q <= v1_q && cand1_q;
            c2_q <= c1_q;
        end
    end

    // ---------------- Stage 3: magnitude and lambda ----------------
    logic [GW-1:0]        abs_re, abs_im, mx, mn;
    logic [MW-1:0]        mag;
    logic [PRW-1:0]       rp_full;
    logic signed [LW-1:0] lam_d;

    // mag = max + min/2; lambda = mag - (rho*phi) >> RHO_FRAC with phi = esum/2.
    always_comb begin
        abs_re  = gsum_re_q[GW-1] ? -gsum_re_q : gsum_re_q;
        abs_im  = gsum_im_q[GW-1] ? -gsum_im_q : gsum_im_q;
        mx      = (abs_re >= abs_im) ? abs_re : abs_im;
        mn      = (abs_re >= abs_im) ? abs_im : abs_re;
        mag     = MW'(mx) + MW'(mn >> 1);
        rp_full = PRW'(esum_q >> 1) * PRW'(rho);
        lam_d   = LW'(mag) - LW'(rp_full >> RHO_FRAC);
    end

    logic signed [LW-1:0] lam3_q;
    logic signed [GW-1:0] g3_re_q, g3_im_q;
    logic                 v3_q;
    logic [NW-1:0]        c3_q;

    // Stage-3 register.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            lam3_q  <= '0;
            g3_re_q <= '0;
            g3_im_q <= '0;
            v3_q    <= 1'b0;
            c3_q    <= '0;
        end else begin
            lam3_q  <= lam_d;
            g3_re_q <= gsum_re_q;
            g3_im_q <= gsum_im_q;
            v3_q    <= v2_q;
            c3_q    <= c2_q;
        end
    end

    // ---------------- Stage 4: running argmax and report ----------------
    logic signed [LW-1:0] max_q, max_d;
    logic [NW-1:0]        idx_q, idx_d;
    logic signed [GW-1:0] mre_q, mre_d, mim_q, mim_d;
    logic                 report;

    // c==0 reloads unconditionally; otherwise strictly greater wins (earliest tie kept).
    always_comb begin
        max_d  = max_q;
        idx_d  = idx_q;
        mre_d  = mre_q;
        mim_d  = mim_q;
        report = 1'b0;
        if (v3_q && ((c3_q == '0) || (lam3_q > max_q))) begin
            max_d = lam3_q;
            idx_d = c3_q;
            mre_d = g3_re_q;
            mim_d = g3_im_q;
        end
        report = v3_q && (c3_q == CLast);
    end

    logic [NW-1:0]        theta_q;
    logic signed [GW-1:0] gre_out_q, gim_out_q;
    logic signed [LW-1:0] lmax_out_q;
    logic                 out_valid_q;

    // Running max state and held outputs; out_valid is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            max_q       <= '0;
            idx_q       <= '0;
            mre_q       <= '0;
            mim_q       <= '0;
            theta_q     <= '0;
            gre_out_q   <= '0;
            gim_out_q   <= '0;
            lmax_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            max_q       <= max_d;
            idx_q       <= idx_d;
            mre_q       <= mre_d;
            mim_q       <= mim_d;
            out_valid_q <= report;
            if (report) begin
                theta_q    <= idx_d;
                gre_out_q  <= mre_d;
                gim_out_q  <= mim_d;
                lmax_out_q <= max_d;
            end
        end
    end

    assign theta      = theta_q;
    assign gamma_re   = gre_out_q;
    assign gamma_im   = gim_out_q;
    assign lambda_max = lmax_out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_ml_sync_core.sv
// Self-checking bench for ml_sync_core (N=16, L=4): a direct-sum golden model pushes the
// expected report when the c==N-1 sample is driven; the monitor pops and compares on
// out_valid, including the 4-cycle latency.
module tb_ml_sync_core;

    localparam int N  = 16;
    localparam int L  = 4;
    localparam int W  = 8;
    localparam int RW = 8;
    localparam int RF = 7;
    localparam int NW = $clog2(N);
    localparam int GW = 2 * W + 1 + $clog2(L);
    localparam int NS = 6 * N;

    logic                 clk = 1'b0;
    logic                 rst, clear, in_valid;
    logic signed [W-1:0]  rx_re_in, rx_img_in;
    logic [RW-1:0]        rho;
    logic [NW-1:0]        theta;
    logic signed [GW-1:0] gamma_re, gamma_im;
    logic signed [GW+1:0] lambda_max;
    logic                 out_valid;

    always #5 clk = ~clk;

    ml_sync_core #(.N(N), .L(L), .W_IN(W), .RHO_W(RW), .RHO_FRAC(RF)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .rx_re_in   (rx_re_in),
        .rx_img_in  (rx_img_in),
        .rho        (rho),
        .theta      (theta),
        .gamma_re   (gamma_re),
        .gamma_im   (gamma_im),
        .lambda_max (lambda_max),
        .out_valid  (out_valid)
    );

    typedef struct {
        longint due;
        longint th;
        longint gre;
        longint gim;
        longint lam;
    } exp_t;

    exp_t   exp_q[$];
    int     hre[$];
    int     him[$];
    int     n_cmp = 0;
    int     n_mis = 0;
    int     n_pulses = 0;
    longint cyc = 0;
    longint m_max, m_idx, m_gre, m_gim;
    longint last_th, last_gre, last_gim, last_lam;
    int     sre[NS];
    int     sim[NS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Direct (non-sliding) evaluation of one candidate ending at accepted index s.
    task automatic model_cand(input int s, output longint gre, output longint gim,
                              output longint lam);
        longint es, ar, ai, mx, mn, phi, rp;
        gre = 0; gim = 0; es = 0;
        for (int k = s - L + 1; k <= s; k++) begin
            longint a, b, c, d;
            a = hre[k]; b = him[k]; c = hre[k-N]; d = him[k-N];
            gre += a * c + b * d;
            gim += b * c - a * d;
            es  += a * a + b * b + c * c + d * d;
        end
        ar  = (gre < 0) ? -gre : gre;
        ai  = (gim < 0) ? -gim : gim;
        mx  = (ar >= ai) ? ar : ai;
        mn  = (ar >= ai) ? ai : ar;
        phi = es / 2;
        rp  = (longint'(rho) * phi) >> RF;
        lam = mx + mn / 2 - rp;
    endtask

    task automatic model_push(input int re_v, input int im_v);
        int     s, c;
        longint gre, gim, lam;
        exp_t   e;
        hre.push_back(re_v);
        him.push_back(im_v);
        s = hre.size() - 1;
        if (s >= N + L - 1) begin
            c = (s - (N + L - 1)) % N;
            model_cand(s, gre, gim, lam);
            if (c == 0 || lam > m_max) begin
                m_max = lam; m_idx = c; m_gre = gre; m_gim = gim;
            end
            if (c == N - 1) begin
                e.due = cyc + 4; e.th = m_idx; e.gre = m_gre; e.gim = m_gim; e.lam = m_max;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic model_clear();
        hre.delete();
        him.delete();
        // Reports that would surface after the clear edge are discarded by the DUT.
        while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
    endtask

    task automatic drive(input logic v, input int re_v, input int im_v, input logic clr);
        @(negedge clk);
        in_valid  = v;
        rx_re_in  = W'(re_v);
        rx_img_in = W'(im_v);
        clear     = clr;
        if (clr) model_clear();
        else if (v) model_push(re_v, im_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(255) - 128, 7, 1'b0);
    endtask

    function automatic int qpsk();
        return ($urandom_range(1) != 0) ? 64 : -64;
    endfunction

    // Random QPSK with samples at offsets off..off+L-1 of each symbol repeated N later.
    task automatic gen_stream(input int off);
        for (int k = 0; k < NS; k++) begin
            sre[k] = qpsk();
            sim[k] = qpsk();
            if (k >= N && (k % N) >= off && (k % N) < off + L) begin
                sre[k] = sre[k-N];
                sim[k] = sim[k-N];
            end
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            n_pulses++;
            last_th = longint'(theta); last_gre = longint'(gamma_re);
            last_gim = longint'(gamma_im); last_lam = longint'(lambda_max);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("latency_cycle", cyc, e.due);
                check_val("theta", last_th, e.th);
                check_val("gamma_re", last_gre, e.gre);
                check_val("gamma_im", last_gim, e.gim);
                check_val("lambda_max", last_lam, e.lam);
            end
        end
    end

    initial begin
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        rx_re_in = '0; rx_img_in = '0; rho = '0;

        // Reset state.
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            rx_re_in = 8'sd50;
            check_val("rst_theta", longint'(theta), 0);
            check_val("rst_gamma_re", longint'(gamma_re), 0);
            check_val("rst_gamma_im", longint'(gamma_im), 0);
            check_val("rst_lambda", longint'(lambda_max), 0);
            check_val("rst_out_valid", longint'(out_valid), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        idle(100);

        // Impulse CP, rho = 0.
        n_pulses = 0;
        for (int s = 0; s < 80; s++) begin
            int v;
            v = ((s >= 5 && s <= 8) || (s >= 21 && s <= 24)) ? 64 : 0;
            drive(1'b1, v, 0, 1'b0);
            if (s == 35) begin
                idle(6);
                check_val("imp_pulses", n_pulses, 1);
                check_val("imp_theta", last_th, 5);
                check_val("imp_gamma_re", last_gre, 16384);
                check_val("imp_gamma_im", last_gim, 0);
            end
        end
        idle(8);

        // Random QPSK with repeated block, rho = 0.5, no gaps.
        rho = 8'd64;
        drive(1'b1, 64, 64, 1'b1);
        gen_stream(5);
        for (int k = 0; k < NS; k++) drive(1'b1, sre[k], sim[k], 1'b0);
        idle(8);

        // Same stream with ~30% idle cycles.
        drive(1'b1, -64, 64, 1'b1);
        for (int k = 0; k < NS; k++) begin
            while ($urandom_range(99) < 30) drive(1'b0, qpsk(), qpsk(), 1'b0);
            drive(1'b1, sre[k], sim[k], 1'b0);
        end
        idle(8);

        // All-zero input: ties resolve to index 0.
        drive(1'b1, 0, 0, 1'b1);
        n_pulses = 0;
        for (int k = 0; k < 4 * N + L; k++) drive(1'b1, 0, 0, 1'b0);
        idle(8);
        check_val("zero_pulses", n_pulses, 3);
        check_val("zero_theta", last_th, 0);
        check_val("zero_gamma_re", last_gre, 0);
        check_val("zero_lambda", last_lam, 0);

        // Clear in the third symbol at c = N/2, then a fresh start.
        drive(1'b1, 0, 0, 1'b1);
        gen_stream(9);
        for (int k = 0; k < N + L - 1 + 2 * N + N / 2; k++) drive(1'b1, sre[k], sim[k], 1'b0);
        n_pulses = 0;
        drive(1'b1, 64, -64, 1'b1);
        for (int k = 0; k < 2 * N + L - 2; k++) drive(1'b1, sre[k], sim[k], 1'b0);
        idle(8);
        check_val("clear_no_pulse", n_pulses, 0);
        for (int k = 2 * N + L - 2; k < 3 * N + L + 2; k++) drive(1'b1, sre[k], sim[k], 1'b0);
        idle(8);
        check_val("clear_pulses", n_pulses, 2);

        check_val("pending_reports", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
